// File: rtl/nphy_toggle_cal_sequencer.sv
// Toggle-mode NAND command/address latch sequencer: one CLE/ALE byte per request, WE pulse, optional CE chaining.
// Optional feature macro NPHY_CAL_WAY_SWITCH_GUARD_EN adds a one-cycle all-CE-high SWITCH state on held-way changes.
module nphy_toggle_cal_sequencer #(
    parameter int NumberOfWays  = 4,
    parameter int WEPulseCycles = 2,
    parameter int WEHoldCycles  = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset_n,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic [7:0]              iCmdAddr,
    input  logic                    iIsAddress,
    input  logic                    iLast,
    output logic                    oDone,
    output logic [NumberOfWays-1:0] oCEToNAND,
    output logic                    oWEToNAND,
    output logic                    oALEToNAND,
    output logic                    oCLEToNAND,
    output logic [7:0]              oDQToNAND,
    output logic [7:0]              oDQOutEnable,
    output logic                    oDQSOutEnable
);

    localparam logic [3:0] PulseLoad = 4'(WEPulseCycles - 1);
    localparam logic [3:0] HoldLoad  = 4'(WEHoldCycles - 1);

`ifdef NPHY_CAL_WAY_SWITCH_GUARD_EN
    typedef enum logic [2:0] {IDLE, SWITCH, SETUP, WE_LOW, WE_HIGH, RELEASE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, WE_LOW, WE_HIGH, RELEASE} state_t;
`endif

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [NumberOfWays-1:0] way_q;
    logic [7:0]              dq_q;
    logic                    addr_q;
    logic                    last_q;
    logic                    held, held_nxt;
    logic [NumberOfWays-1:0] sel_way;
    logic                    accept;

    // Isolate the lowest set bit; an empty request falls back to way 0.
    function automatic logic [NumberOfWays-1:0] lowest_way(input logic [NumberOfWays-1:0] req);
        if (req == '0) return NumberOfWays'(1);
        return req & (~req + NumberOfWays'(1));
    endfunction

    assign sel_way       = lowest_way(iTargetWay);
    assign accept        = (state == IDLE) && iValid;
    assign oDQToNAND     = dq_q;
    assign oDQSOutEnable = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            way_q  <= '0;
            dq_q   <= 8'h00;
            addr_q <= 1'b0;
            last_q <= 1'b0;
            held   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            held  <= held_nxt;
            if (accept) begin
                way_q  <= sel_way;
                dq_q   <= iCmdAddr;
                addr_q <= iIsAddress;
                last_q <= iLast;
            end
        end
    end

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        held_nxt     = held;
        oReady       = 1'b0;
        oDone        = 1'b0;
        oCEToNAND    = '1;
        oWEToNAND    = 1'b1;
        oALEToNAND   = 1'b0;
        oCLEToNAND   = 1'b0;
        oDQOutEnable = 8'hFF;

        unique case (state)
            IDLE: begin
                oReady = 1'b1;
                if (held) oCEToNAND = ~way_q;
                if (iValid) begin
`ifdef NPHY_CAL_WAY_SWITCH_GUARD_EN
                    state_nxt = (held && (sel_way != way_q)) ? SWITCH : SETUP;
`else
                    state_nxt = SETUP;
`endif
                end
            end
`ifdef NPHY_CAL_WAY_SWITCH_GUARD_EN
            SWITCH: begin
                state_nxt = SETUP;
            end
`endif
            SETUP, WE_LOW, WE_HIGH: begin
                oCEToNAND    = ~way_q;
                oALEToNAND   = addr_q;
                oCLEToNAND   = ~addr_q;
                oDQOutEnable = 8'h00;
                if (state == SETUP) begin
                    state_nxt = WE_LOW;
                    cnt_nxt   = PulseLoad;
                end else if (state == WE_LOW) begin
                    oWEToNAND = 1'b0;
                    if (cnt == 4'd0) begin
                        state_nxt = WE_HIGH;
                        cnt_nxt   = HoldLoad;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end else if (cnt == 4'd0) begin
                    // Last hold cycle: a non-final byte keeps its CE low through IDLE.
                    oDone     = 1'b1;
                    state_nxt = last_q ? RELEASE : IDLE;
                    held_nxt  = ~last_q;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RELEASE: begin
                held_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nphy_toggle_cal_sequencer.sv
// Scoreboard bench for nphy_toggle_cal_sequencer: driver queues expected bytes, a negedge monitor checks each byte.
module tb_nphy_toggle_cal_sequencer;

    localparam int P = 2;
    localparam int H = 2;
    localparam int N = 1 + P + H;
`ifdef NPHY_CAL_WAY_SWITCH_GUARD_EN
    localparam int SW = 1;
`else
    localparam int SW = 0;
`endif

    typedef struct {
        logic [7:0] dq;
        logic       is_addr;
        logic       last;
        logic [3:0] ce;
        int         sw;
    } exp_t;

    logic       clk, rst_n;
    logic       valid, ready, is_addr, last, done, we, ale, cle, dqs_oe;
    logic [3:0] way, ce;
    logic [7:0] cmd, dq, oe;

    logic       b_valid, b_ready, b_addr, b_last, b_done, b_we, b_ale, b_cle, b_dqs_oe;
    logic [3:0] b_way, b_ce;
    logic [7:0] b_cmd, b_dq, b_oe;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    exp_t cur;
    logic mon_busy = 1'b0;
    logic hold     = 1'b0;
    logic [3:0] hold_ce;
    int   post = 0;
    int   lat, we_low, we_high, sw_cnt, ce_bad, dq_bad, oe_cnt, ale_cnt, cle_cnt, gap_bad;

    nphy_toggle_cal_sequencer dut (
        .iSystemClock (clk),
        .iReset_n     (rst_n),
        .iValid       (valid),
        .oReady       (ready),
        .iTargetWay   (way),
        .iCmdAddr     (cmd),
        .iIsAddress   (is_addr),
        .iLast        (last),
        .oDone        (done),
        .oCEToNAND    (ce),
        .oWEToNAND    (we),
        .oALEToNAND   (ale),
        .oCLEToNAND   (cle),
        .oDQToNAND    (dq),
        .oDQOutEnable (oe),
        .oDQSOutEnable(dqs_oe)
    );

    nphy_toggle_cal_sequencer #(.NumberOfWays(4), .WEPulseCycles(1), .WEHoldCycles(15)) dut_b (
        .iSystemClock (clk),
        .iReset_n     (rst_n),
        .iValid       (b_valid),
        .oReady       (b_ready),
        .iTargetWay   (b_way),
        .iCmdAddr     (b_cmd),
        .iIsAddress   (b_addr),
        .iLast        (b_last),
        .oDone        (b_done),
        .oCEToNAND    (b_ce),
        .oWEToNAND    (b_we),
        .oALEToNAND   (b_ale),
        .oCLEToNAND   (b_cle),
        .oDQToNAND    (b_dq),
        .oDQOutEnable (b_oe),
        .oDQSOutEnable(b_dqs_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: pops the expected byte at each handshake, accumulates per-cycle pad behaviour, judges at oDone.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
            hold     = 1'b0;
            post     = 0;
        end else begin
            if (mon_busy) begin
                lat++;
                if (ce == 4'hF && oe == 8'hFF) sw_cnt++;
                else if (ce != cur.ce) ce_bad++;
                if (!we) we_low++;
                else if (we_low > 0) we_high++;
                if (ale) ale_cnt++;
                if (cle) cle_cnt++;
                if (oe == 8'h00) begin
                    oe_cnt++;
                    if (dq != cur.dq) dq_bad++;
                end
                if (done) begin
                    check("latency", lat, 1 + P + H + cur.sw);
                    check("we_low_cycles", we_low, P);
                    check("we_high_cycles", we_high, H);
                    check("switch_cycles", sw_cnt, cur.sw);
                    check("ce_select_errors", ce_bad, 0);
                    check("dq_errors", dq_bad, 0);
                    check("drive_cycles", oe_cnt, N);
                    check("ale_cycles", ale_cnt, cur.is_addr ? N : 0);
                    check("cle_cycles", cle_cnt, cur.is_addr ? 0 : N);
                    mon_busy = 1'b0;
                    hold     = ~cur.last;
                    hold_ce  = cur.ce;
                    gap_bad  = 0;
                    post     = cur.last ? 1 : 3;
                end
            end else begin
                if (done) fail_now("unexpected_done");
                if (post == 1) begin
                    check("release_ce", ce, 4'hF);
                    check("release_ready", ready, 1'b0);
                    post = 2;
                end else if (post == 2) begin
                    check("ready_after_release", ready, 1'b1);
                    post = 0;
                end else if (post == 3) begin
                    check("ready_after_chain", ready, 1'b1);
                    post = 0;
                end
                if (hold && ce != hold_ce) gap_bad++;
            end
            if (valid && ready) begin
                if (hold) check("held_ce_gap", gap_bad, 0);
                hold = 1'b0;
                if (sb.size() == 0) begin
                    fail_now("unexpected_accept");
                end else begin
                    cur      = sb.pop_front();
                    mon_busy = 1'b1;
                    lat = 0; we_low = 0; we_high = 0; sw_cnt = 0; ce_bad = 0;
                    dq_bad = 0; oe_cnt = 0; ale_cnt = 0; cle_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic a, input logic l, input logic [3:0] w,
                        input logic [3:0] exp_ce, input int sw);
        int   guard;
        exp_t e;
        cmd = b; is_addr = a; last = l; way = w; valid = 1'b1;
        guard = 0;
        while (!ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) begin
            fail_now("send_timeout");
            valid = 1'b0;
            return;
        end
        e.dq = b; e.is_addr = a; e.last = l; e.ce = exp_ce; e.sw = sw;
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || mon_busy || !ready || post != 0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) fail_now("idle_timeout");
    endtask

    task automatic run_b(input logic l, input int exp_occ);
        int lo, hi, n, dn;
        check("b_ready_before", b_ready, 1'b1);
        b_cmd = 8'h3C; b_addr = 1'b0; b_last = l; b_way = 4'b0010; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lo = 0; hi = 0; n = 0; dn = 0;
        while (!b_ready && n < 100) begin
            if (!b_we) lo++;
            else if (lo > 0 && b_cle) hi++;
            if (b_done) dn++;
            n++;
            @(posedge clk); #1;
        end
        check("b_we_low", lo, 1);
        check("b_we_high", hi, 15);
        check("b_occupancy", n, exp_occ);
        check("b_done_pulses", dn, 1);
    endtask

    initial begin
        valid = 0; cmd = 0; is_addr = 0; last = 0; way = 0;
        b_valid = 0; b_cmd = 0; b_addr = 0; b_last = 0; b_way = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_ce", ce, 4'hF);
        check("reset_we", we, 1'b1);
        check("reset_ale_cle", {ale, cle}, 2'b00);
        check("reset_dq", dq, 8'h00);
        check("reset_oe", oe, 8'hFF);
        check("reset_dqs_oe", dqs_oe, 1'b1);
        check("reset_done", done, 1'b0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single command byte, released after.
        send(8'h70, 1'b0, 1'b1, 4'b0001, 4'b1110, 0);
        wait_idle();

        // Command plus five address bytes chained on way 2.
        send(8'h00, 1'b0, 1'b0, 4'b0100, 4'b1011, 0);
        send(8'h11, 1'b1, 1'b0, 4'b0100, 4'b1011, 0);
        send(8'h22, 1'b1, 1'b0, 4'b0100, 4'b1011, 0);
        send(8'h33, 1'b1, 1'b0, 4'b0100, 4'b1011, 0);
        send(8'h44, 1'b1, 1'b0, 4'b0100, 4'b1011, 0);
        send(8'h55, 1'b1, 1'b1, 4'b0100, 4'b1011, 0);
        wait_idle();

        // Way change while CE is held.
        send(8'h80, 1'b0, 1'b0, 4'b0001, 4'b1110, 0);
        send(8'h90, 1'b0, 1'b1, 4'b1000, 4'b0111, SW);
        wait_idle();

        // Non-one-hot and empty way selects.
        send(8'hC1, 1'b1, 1'b1, 4'b0110, 4'b1101, 0);
        send(8'hC2, 1'b0, 1'b1, 4'b0000, 4'b1110, 0);
        wait_idle();

        // iValid held high with a changing byte: only handshake cycles are queued.
        valid = 1'b1; way = 4'b0001; is_addr = 1'b0; last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd = 8'hA0 + 8'(i);
            if (ready) begin
                exp_t e;
                e.dq = cmd; e.is_addr = 1'b0; e.last = 1'b1; e.ce = 4'b1110; e.sw = 0;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        wait_idle();

        // Reset in the second WE_LOW cycle.
        send(8'h5A, 1'b0, 1'b1, 4'b0010, 4'b1101, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_we", we, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_we", we, 1'b1);
        check("abort_ce", ce, 4'hF);
        check("abort_oe", oe, 8'hFF);
        check("abort_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", ready, 1'b1);
        check("post_reset_ce", ce, 4'hF);
        check("post_reset_dq", dq, 8'h00);
        repeat (8) @(posedge clk);
        #1;

        // Short pulse / long hold instance.
        run_b(1'b1, 18);
        run_b(1'b0, 17);
        check("b_held_ce", b_ce, 4'b1101);
        run_b(1'b1, 18);

        wait_idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nphy_toggle_cal_sequencer.md
NPHY_TOGGLE_CAL_SEQUENCER -- requirements
Module: nphy_toggle_cal_sequencer

Interface
REQ-001 Parameter NumberOfWays, default 4: number of NAND CE/ways driven.
REQ-002 Parameter WEPulseCycles, default 2, legal range 1..15: WE low width in clocks.
REQ-003 Parameter WEHoldCycles, default 2, legal range 1..15: WE high hold in clocks after the WE rising edge.
REQ-004 iSystemClock  in  1  sole clock; all state on its rising edge.
REQ-005 iReset_n  in  1  reset, asynchronous, active-low.
REQ-006 iValid  in  1  request valid: one command or address byte.
REQ-007 oReady  out  1  sequencer can accept a request.
REQ-008 iTargetWay  in  NumberOfWays  one-hot way select.
REQ-009 iCmdAddr  in  8  command/address byte.
REQ-010 iIsAddress  in  1  1 = address cycle (ALE), 0 = command cycle (CLE).
REQ-011 iLast  in  1  1 = release CE after this byte; 0 = keep CE low for a chained byte.
REQ-012 oDone  out  1  one-cycle pulse when a byte's hold phase completes.
REQ-013 oCEToNAND  out  NumberOfWays  CE, active-low.
REQ-014 oWEToNAND, oALEToNAND, oCLEToNAND  out  1 each  pad-side WE/ALE/CLE.
REQ-015 oDQToNAND  out  8  data to the DQ pads; oDQOutEnable  out  8  0 = drive, 1 = hi-Z.
REQ-016 oDQSOutEnable  out  1  held at 1 (DQS hi-Z) at all times.

Function
REQ-017 The block SHALL use states IDLE, SWITCH, SETUP, WE_LOW, WE_HIGH, RELEASE.
REQ-018 oReady SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with iValid=1 and oReady=1, capturing all request inputs; inputs on other cycles SHALL be ignored.
REQ-019 IDLE->SETUP on acceptance, except IDLE->SWITCH when CE is held low and the captured way differs from the held way.
REQ-020 SETUP (1 cycle): selected CE=0, ALE or CLE=1 per iIsAddress, oDQToNAND=byte, oDQOutEnable=8'h00, WE=1.
REQ-021 WE_LOW: WE=0 for exactly WEPulseCycles cycles; all other outputs as in SETUP.
REQ-022 WE_HIGH: WE=1 for exactly WEHoldCycles cycles; ALE/CLE, DQ and CE stay unchanged; oDone=1 on the last WE_HIGH cycle only.
REQ-023 After WE_HIGH: iLast=1 -> RELEASE; iLast=0 -> IDLE with the way's CE held at 0.
REQ-024 RELEASE (1 cycle): all CE=1; then IDLE.
REQ-025 In IDLE, RELEASE and SWITCH: ALE=CLE=0, WE=1, oDQOutEnable=8'hFF, oDQToNAND holds its last value.
REQ-026 Occupancy per byte from the acceptance edge: 1+WEPulseCycles+WEHoldCycles cycles, plus 1 for RELEASE and plus 1 for SWITCH.
REQ-027 Only one CE bit SHALL be 0 at any time; a non-one-hot iTargetWay SHALL select its lowest set bit, and all-zero SHALL select way 0.
REQ-028 The phase counter SHALL be 4 bits, load the parameter value minus 1 on phase entry and never wrap.

Reset
REQ-029 On iReset_n=0, immediately and regardless of state: state=IDLE, oCEToNAND all 1, WE=1, ALE=CLE=0, oDQToNAND=8'h00, oDQOutEnable=8'hFF, oDQSOutEnable=1, oDone=0, held-way cleared.
REQ-030 A reset during any phase SHALL abort the byte with no oDone pulse; oReady=1 on the first clock after deassertion.

Configuration
REQ-031 Macro NPHY_CAL_WAY_SWITCH_GUARD_EN: when defined, a way change while CE is held SHALL pass through SWITCH (1 cycle, all CE=1) before SETUP.
REQ-032 Without NPHY_CAL_WAY_SWITCH_GUARD_EN, SWITCH SHALL not exist: SETUP raises the old CE and lowers the new one on the same cycle.

Verification
REQ-033 Defaults, accept 0x70 command, iLast=1, way 4'b0001 -> CLE=1 for 5 cycles, WE low exactly 2 cycles, oDone on cycle 5, CE0 high on cycle 6, oReady on cycle 7.
REQ-034 Chain 0x00 (cmd, iLast=0) then 5 address bytes (last iLast=1) on way 2 -> CE2 low continuously, 6 WE pulses, ALE only on address bytes, 6 oDone pulses.
REQ-035 Chained byte on way 0, then new byte on way 3 with guard macro on -> exactly one cycle with CE=4'b1111 before CE3=0; macro off -> zero such cycles.
REQ-036 Assert iReset_n=0 in the second WE_LOW cycle -> same cycle: WE=1, CE all 1, oDQOutEnable=8'hFF; no oDone pulse.
REQ-037 iValid held high with varying iCmdAddr while busy -> only bytes present on oReady=1 cycles appear on oDQToNAND.
REQ-038 WEPulseCycles=1, WEHoldCycles=15 -> WE low 1 cycle, high 15 cycles, occupancy 17 cycles (18 with iLast=1).
